shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 133 +++++++++++++
 tb/tb_shift_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Multi-cycle barrel-less shifter: shifts a 64-bit operand STEP bits per cycle
// through IDLE/SHIFT/DONE with a valid/ready result handshake. Define SHIFT_SEQ_ROR_EN to enable op=11 (ROR).
module shift_seq #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [31:0] ibus,
  input  logic [1:0]  op,
  input  logic [63:0] din,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        flush,
  output logic [63:0] dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err,
  output logic        busy
);

  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
    $error("shift_seq: STEP must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LSL = 2'b00, OP_LSR = 2'b01, OP_ASR = 2'b10, OP_ROR = 2'b11} shift_op_t;

  localparam logic [5:0] STEP6 = 6'(STEP);

  state_t      state_q, state_d;
  shift_op_t   op_q, op_d;
  logic [63:0] work_q, work_d;
  logic [5:0]  rem_q, rem_d;
  logic        err_q, err_d;

  logic [5:0]  step_k;
  logic [63:0] stepped;
  logic        unsupported;
  logic        ibus_unused;

  // Only the shift-amount field of the instruction word is decoded here.
  assign ibus_unused = ^{ibus[31:16], ibus[9:0]};

`ifdef SHIFT_SEQ_ROR_EN
  assign unsupported = 1'b0;
`else
  assign unsupported = (shift_op_t'(op) == OP_ROR);
`endif

  assign step_k = (rem_q < STEP6) ? rem_q : STEP6;

  // One partial shift of the working register; ASR keeps bit 63 so the fill
  // always matches the original operand's sign.
  always_comb begin
    stepped = work_q;
    unique case (op_q)
      OP_LSL: stepped = work_q << step_k;
      OP_LSR: stepped = work_q >> step_k;
      OP_ASR: stepped = 64'($signed(work_q) >>> step_k);
      OP_ROR: begin
`ifdef SHIFT_SEQ_ROR_EN
        stepped = (work_q >> step_k) | (work_q << (7'd64 - {1'b0, step_k}));
`else
        stepped = work_q;
`endif
      end
      default: stepped = work_q;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    rem_d   = rem_q;
    err_d   = err_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            work_d = din;
            op_d   = shift_op_t'(op);
            rem_d  = ibus[15:10];
            err_d  = unsupported;
            if (unsupported || ibus[15:10] == 6'd0) begin
              rem_d   = 6'd0;
              state_d = S_DONE;
            end else begin
              state_d = S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          work_d = stepped;
          rem_d  = rem_q - step_k;
          if (rem_q == step_k) state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    // NOTE: datapath registers are reset too, because dout and err have defined reset values.
    if (!nreset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LSL;
      work_q  <= 64'h0;
      rem_q   <= 6'd0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign dout      = work_q;
  assign err       = err_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq (STEP=4): a result/latency model computed
// from whole-word shifts, a per-cycle compare process, and directed literal cases.
module tb_shift_seq;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [31:0] ibus = '0;
  logic [1:0]  op = '0;
  logic [63:0] din = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic [63:0] dout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_seq #(.STEP(STEP)) dut (
    .clk(clk), .nreset(nreset), .ibus(ibus), .op(op), .din(din),
    .req_valid(req_valid), .req_ready(req_ready), .flush(flush),
    .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit is_unsup(input logic [1:0] o);
`ifdef SHIFT_SEQ_ROR_EN
    return 1'b0;
`else
    return o == 2'b11;
`endif
  endfunction

  // Whole-word reference: apply the shift one bit at a time, sh times.
  function automatic logic [63:0] ref_shift(input logic [1:0] o, input logic [63:0] d, input logic [5:0] sh);
    logic [63:0] r;
    r = d;
    if (is_unsup(o)) return d;
    for (int i = 0; i < int'(sh); i++) begin
      case (o)
        2'b00:   r = {r[62:0], 1'b0};
        2'b01:   r = {1'b0, r[63:1]};
        2'b10:   r = {r[63], r[63:1]};
        default: r = {r[0], r[63:1]};
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [5:0] sh);
    if (is_unsup(o)) return 0;
    return (int'(sh) + STEP - 1) / STEP;
  endfunction

  logic        m_busy, m_valid, m_err;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_res   <= '0;
      m_left  <= 0;
    end else if (flush) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  <= 1'b1;
        m_left  <= exp_lat(op, ibus[15:10]);
        m_valid <= (exp_lat(op, ibus[15:10]) == 0);
        m_res   <= ref_shift(op, din, ibus[15:10]);
        m_err   <= is_unsup(op);
      end
    end else if (!m_valid) begin
      if (m_left == 1) m_valid <= 1'b1;
      m_left <= m_left - 1;
    end else if (out_ready) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (nreset) begin
      check("req_ready", 64'(req_ready), 64'(!m_busy));
      check("busy", 64'(busy), 64'(m_busy));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        check("dout", dout, m_res);
        check("err", 64'(err), 64'(m_err));
      end
    end
  end

  // Called at #1 after an accepting edge; counts edges until out_valid.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      op   = 2'($urandom);
      din  = {$urandom, $urandom};
      ibus = 32'($urandom);
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  // Called at #1 after an edge with the DUT idle.
  task automatic run_op(input logic [1:0] o, input logic [63:0] d, input logic [5:0] sh,
                        input int hold, output int lat, output logic [63:0] res, output logic e);
    req_valid = 1'b1;
    op        = o;
    din       = d;
    ibus      = 32'($urandom);
    ibus[15:10] = sh;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid(lat);
    res = dout;
    e   = err;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic start_lsl40();
    req_valid = 1'b1;
    op        = 2'b00;
    din       = 64'h0123_4567_89AB_CDEF;
    ibus      = '0;
    ibus[15:10] = 6'd40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [63:0] res;
    logic        e;

    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_dout", dout, 64'h0);
    nreset = 1'b1;

    run_op(2'b00, 64'h1, 6'd63, 0, lat, res, e);
    check("lsl63_lat", 64'(lat), 64'd16);
    check("lsl63_dout", res, 64'h8000_0000_0000_0000);
    check("lsl63_err", 64'(e), 64'd0);

    run_op(2'b10, 64'h8000_0000_0000_0000, 6'd5, 1, lat, res, e);
    check("asr5_lat", 64'(lat), 64'd2);
    check("asr5_dout", res, 64'hFC00_0000_0000_0000);

    run_op(2'b01, 64'h8000_0000_0000_0000, 6'd5, 0, lat, res, e);
    check("lsr5_lat", 64'(lat), 64'd2);
    check("lsr5_dout", res, 64'h0400_0000_0000_0000);

    run_op(2'b00, 64'hDEAD_BEEF_0123_4567, 6'd0, 0, lat, res, e);
    check("sh0_lat", 64'(lat), 64'd0);
    check("sh0_dout", res, 64'hDEAD_BEEF_0123_4567);

    run_op(2'b11, 64'h1, 6'd1, 0, lat, res, e);
`ifdef SHIFT_SEQ_ROR_EN
    check("ror1_lat", 64'(lat), 64'd1);
    check("ror1_dout", res, 64'h8000_0000_0000_0000);
    check("ror1_err", 64'(e), 64'd0);
`else
    check("ror1_lat", 64'(lat), 64'd0);
    check("ror1_dout", res, 64'h1);
    check("ror1_err", 64'(e), 64'd1);
`endif

    // Backpressure: result held while new requests are offered.
    req_valid = 1'b1;
    op        = 2'b10;
    din       = 64'h8000_0000_0000_0000;
    ibus      = '0;
    ibus[15:10] = 6'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid(lat);
    repeat (5) begin
      req_valid = 1'b1;
      din       = {$urandom, $urandom};
      @(posedge clk); #1;
      check("bp_dout", dout, 64'hFC00_0000_0000_0000);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_ready", 64'(req_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);

    // Flush on the third SHIFT edge.
    start_lsl40();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_req_ready", 64'(req_ready), 64'd1);
    repeat (12) begin
      @(posedge clk); #1;
      check("flush_no_valid", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset mid-SHIFT, checked before any further clock edge.
    start_lsl40();
    #2 nreset = 1'b0;
    #1;
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    check("arst_dout", dout, 64'h0);
    @(posedge clk); #1;
    nreset = 1'b1;

    // Sweep every op and shift amount; the compare process checks each result.
    for (int o = 0; o < 4; o++) begin
      for (int s = 0; s < 64; s++) begin
        logic [63:0] pat;
        pat = {$urandom, $urandom};
        pat[63] = s[0];
        run_op(2'(o), pat, 6'(s), s % 3, lat, res, e);
        check("sweep_lat", 64'(lat), 64'(exp_lat(2'(o), 6'(s))));
        check("sweep_dout", res, ref_shift(2'(o), pat, 6'(s)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
